nand_tree_pipe: RTL
===================

Name: nand_tree_pipe

Overview:
Parametrised, pipelined successor to the team's 2-input NAND gate. It reduces NIN operands, each WIDTH bits, bitwise through a registered binary tree. The result is one WIDTH-bit word under a selectable logic op (NAND/AND/NOR/OR). Valid/ready handshake on both sides lets it drop into streaming datapaths; NIN=2, WIDTH=1 with op NAND reproduces the original gate with registered timing.

Parameters:
WIDTH, 8, bits per operand and per result
NIN, 4, number of operands reduced; legal 2..16
LAT, $clog2(NIN) (derived localparam), pipeline depth in cycles

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_op  in  2  op select: 00 NAND, 01 AND, 10 NOR, 11 OR
in_data  in  NIN*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_op  out  2  op that produced out_data
out_data  out  WIDTH  reduction result

Behaviour:
- Reset: synchronous, active-high. One clk edge with rst=1 clears all stage valid bits, out_valid=0, out_data=0, out_op=00. in_ready reads 1 on the first cycle after reset. Beats presented while rst=1 are discarded.
- Pipeline: LAT register stages, one per tree level. Stage s holds ceil(NIN/2^s) partial words, plus a valid bit and the op (2b).
- Reduction: each level combines pairs. Ops 00/01 use bitwise AND; ops 10/11 use bitwise OR. The final stage inverts for NAND (00) and NOR (10).
- Odd partial count at any level: the unpaired word passes through unchanged. This is equivalent to padding with the identity (all-ones for AND, all-zeros for OR), so results are correct for any NIN.
- Advance: adv = !out_valid || out_ready. This is a global stall: all stages shift together when adv=1 and hold data, op and valid when adv=0. in_ready = adv, combinational.
- Transfer rules:
  - A beat is accepted when in_valid && in_ready.
  - With continuous flow, the result appears with out_valid=1 exactly LAT cycles after acceptance.
  - A result is consumed when out_valid && out_ready.
- Bubbles: invalid beats occupy stages and are not collapsed. Throughput is 1 beat/cycle when out_ready=1.
- Stall: out_data and out_op stay stable while out_valid=1 && out_ready=0. Beat order is preserved; no beat is lost or duplicated.
- Simultaneous consume and accept: allowed in the same cycle with no bubble inserted.
- in_op and in_data are sampled only on acceptance. Changes at other times have no effect.
- Reset mid-operation: all in-flight beats are dropped. No stale result appears after rst deasserts.

Decomposition:
- Shared package nand_pkg:
  - op_t 2-bit typedef
  - constants OP_NAND=2'b00, OP_AND=2'b01, OP_NOR=2'b10, OP_OR=2'b11
  - function is_or_class(op)
  - function final_invert(op)
- Sub-module nand_tree_stage: one registered pairwise-reduction level.
  - Parameters: WIDTH and input word count.
  - Carries valid and op; has an enable input driven by adv.
  - nand_tree_pipe instantiates LAT of these via generate and adds the output inversion.

Test Plan:
- NIN=4, WIDTH=8, NAND: {FF,FF,FF,FF} -> 00; {FF,0F,FF,FF} -> F0. Each result has out_valid=1 exactly 2 cycles after acceptance.
- Ops, back-to-back beats at 1/cycle:
  - AND {F0,3C,FF,FF} -> 30
  - NOR {01,02,04,00} -> F8
  - OR {01,02,04,00} -> 07
  - out_op matches each beat's op.
- Backpressure: stream 6 beats, hold out_ready=0 for 5 cycles mid-stream.
  - in_ready=0 while out_valid=1.
  - out_data stays stable during the stall.
  - All 6 results arrive in order, with no loss or duplication.
- NIN=3, WIDTH=8: NAND {FF,FF,FF} -> 00; NAND {FF,FF,FE} -> 01; OR {00,00,00} -> 00; latency 2.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight. out_valid=0 the following cycle, and no result emerges afterwards until a new beat is accepted.
- NIN=2, WIDTH=1, NAND truth table: 00->1, 01->1, 10->1, 11->0, latency 1. This matches the original 2-input NAND gate.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared types and helpers for the pipelined NAND/AND/NOR/OR reduction tree.
package nand_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NAND = 2'b00;
  localparam op_t OP_AND  = 2'b01;
  localparam op_t OP_NOR  = 2'b10;
  localparam op_t OP_OR   = 2'b11;

  // NOR/OR reduce with bitwise OR; NAND/AND reduce with bitwise AND.
  function automatic logic is_or_class(op_t op);
    return op[1];
  endfunction

  // NAND and NOR invert the reduced word on the way out.
  function automatic logic final_invert(op_t op);
    return ~op[0];
  endfunction

  // Number of partial words left after s pairwise levels starting from n words.
  function automatic int level_words(int n, int s);
    int w;
    w = n;
    for (int i = 0; i < s; i++) w = (w + 1) / 2;
    return w;
  endfunction

endpackage

// File: rtl/nand_tree_stage.sv
// One registered level of the reduction tree: combines word pairs, an odd
// trailing word passes through unchanged (identity padding for AND and OR).
module nand_tree_stage
  import nand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               in_valid,
  input  logic [1:0]                         in_op,
  input  logic [N_IN*WIDTH-1:0]              in_data,
  output logic                               out_valid,
  output logic [1:0]                         out_op,
  output logic [((N_IN+1)/2)*WIDTH-1:0]      out_data
);

  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_OUT*WIDTH-1:0] reduced;
  logic                   use_or;

  assign use_or = is_or_class(op_t'(in_op));

  for (genvar k = 0; k < N_OUT; k++) begin : g_pair
    if (2 * k + 1 < N_IN) begin : g_combine
      assign reduced[k*WIDTH +: WIDTH] = use_or
        ? (in_data[(2*k)*WIDTH +: WIDTH] | in_data[(2*k+1)*WIDTH +: WIDTH])
        : (in_data[(2*k)*WIDTH +: WIDTH] & in_data[(2*k+1)*WIDTH +: WIDTH]);
    end else begin : g_pass
      assign reduced[k*WIDTH +: WIDTH] = in_data[(2*k)*WIDTH +: WIDTH];
    end
  end

  // Whole-pipeline stall: when en is low every field holds, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= OP_NAND;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_op    <= in_op;
      out_data  <= reduced;
    end
  end

endmodule

// File: rtl/nand_tree_pipe.sv
// Pipelined NIN-operand bitwise NAND/AND/NOR/OR reduction with valid/ready on
// both sides; NIN=2, WIDTH=1, op NAND behaves as a registered 2-input NAND.
module nand_tree_pipe
  import nand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [NIN*WIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [WIDTH-1:0]       out_data
);

  localparam int LAT = $clog2(NIN);

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < LAT; s++) begin : g_lvl
    localparam int N_I = level_words(NIN, s);
    localparam int N_O = level_words(NIN, s + 1);

    logic                 v_in;
    logic [1:0]           op_in;
    logic [N_I*WIDTH-1:0] d_in;
    logic                 v_out;
    logic [1:0]           op_out;
    logic [N_O*WIDTH-1:0] d_out;

    if (s == 0) begin : g_first
      assign v_in  = in_valid;
      assign op_in = in_op;
      assign d_in  = in_data;
    end else begin : g_next
      assign v_in  = g_lvl[s-1].v_out;
      assign op_in = g_lvl[s-1].op_out;
      assign d_in  = g_lvl[s-1].d_out;
    end

    nand_tree_stage #(
      .WIDTH (WIDTH),
      .N_IN  (N_I)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (v_in),
      .in_op     (op_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_op    (op_out),
      .out_data  (d_out)
    );
  end

  logic [WIDTH-1:0] tree_data;
  logic [1:0]       tree_op;

  assign tree_data = g_lvl[LAT-1].d_out;
  assign tree_op   = g_lvl[LAT-1].op_out;
  assign out_valid = g_lvl[LAT-1].v_out;
  assign out_op    = tree_op;

  // Idle output reads zero so a cleared pipe never shows the inverted reset word.
  assign out_data = !out_valid                   ? '0
                  : final_invert(op_t'(tree_op)) ? ~tree_data
                  :                                tree_data;

endmodule
